// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC generator, imem request/response, prefetch queue.
// Optional FETCH_BYPASS_EN: empty-queue responses reach the decoder same cycle.
package fetch_pkg;
  typedef logic [31:0] instruction_t;

  typedef struct packed {
    instruction_t data;
    logic [31:0]  pc;
    logic         fault;
  } fq_entry_t;
endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);

  fq_entry_t   mem [QUEUE_DEPTH];
  fq_entry_t   hold;
  fq_entry_t   head_e;
  fq_entry_t   rsp_e;
  fq_entry_t   cur;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   redir_al;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [CW:0]   used;

  logic have;
  logic req_fire;
  logic rsp_keep;
  logic byp;
  logic byp_take;
  logic push;
  logic pop;

  assign redir_al = redirect_pc & 32'hFFFF_FFFC;
  assign used     = {1'b0, count} + {1'b0, inflight};
  assign have     = count != '0;

  // reset gate keeps the request idle while reset is held
  assign imem_req_valid = !reset && !redirect_valid
                        && (used < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && !redirect_valid
                  && (discard == '0);

`ifdef FETCH_BYPASS_EN
  assign byp = !reset && rsp_keep && !have;
`else
  assign byp = 1'b0;
`endif

  assign byp_take = byp && instr_ready;
  assign push     = rsp_keep && !byp_take;
  assign pop      = have && instr_ready && !redirect_valid;

  assign head_e = mem[head];

  always_comb begin
    rsp_e       = '0;
    rsp_e.data  = imem_rsp_data;
    rsp_e.pc    = rsp_pc;
    rsp_e.fault = imem_rsp_err;
  end

  always_comb begin
    cur = hold;
    unique case (1'b1)
      have:    cur = head_e;
      byp:     cur = rsp_e;
      default: cur = hold;
    endcase
  end

  assign instr_valid = have || byp;
  assign instr       = cur.data;
  assign instr_pc    = cur.pc;
  assign instr_fault = cur.fault;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= rsp_e;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold <= '0;
    end else if (instr_valid) begin
      hold <= cur;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      discard  <= '0;
    end else if (redirect_valid) begin
      // everything still in flight belongs to the old stream
      fetch_pc <= redir_al;
      rsp_pc   <= redir_al;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      discard  <= inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (rsp_keep) begin
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (imem_rsp_valid && discard != '0) begin
        discard <= discard - CW'(1);
      end
      if (push) begin
        tail <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire)
                - CW'(imem_rsp_valid);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random memory/decoder/redirect traffic against a
// stream-level reference model of the fetch unit.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (RST_PC),
    .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_fault   (instr_fault)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t pend[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_due = 0;
  int n_acc = 0;
  int occ = 0;
  int mdisc = 0;
  int p_rdy = 100;
  int p_dec = 100;
  int p_redir = 0;
  int lat_min = 1;
  int lat_max = 1;

  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  logic [31:0] lastpc;
  logic [31:0] lastdat;
  logic [31:0] f_tgt;
  logic        f_redir = 1'b0;
  logic        prev_redir;
  logic        found;

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  function automatic logic ferr(input logic [31:0] a);
    return a[5:2] == 4'd2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_instr_fault", instr_fault, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend.delete();
    occ        = 0;
    mdisc      = 0;
    exp_pc     = RST_PC;
    exp_fetch  = RST_PC;
    lastpc     = '0;
    lastdat    = '0;
    prev_redir = 1'b0;
    n_acc      = 0;
  endtask

  task automatic step();
    logic ev, byp, pop, acc, rsp;
    int lat, due;
    @(posedge clk);
    #1;
    imem_req_ready = ($urandom_range(99) < p_rdy);
    instr_ready    = ($urandom_range(99) < p_dec);
    if (f_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = f_tgt;
      f_redir        = 1'b0;
    end else begin
      redirect_valid = ($urandom_range(999) < p_redir);
      redirect_pc    = $urandom;
    end
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = fdat(pend[0].addr);
      imem_rsp_err   = ferr(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      imem_rsp_err   = 1'($urandom_range(1));
    end
    @(negedge clk);
    rsp = imem_rsp_valid;
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = occ == 0 && mdisc == 0 && !redirect_valid && rsp;
`endif
    ev = occ != 0 || byp;
    chk("req_valid", imem_req_valid,
        !redirect_valid && (occ + pend.size() < DEPTH));
    chk("instr_valid", instr_valid, ev);
    if (prev_redir) chk("valid_after_redir", instr_valid, 0);
    if (rsp) chk("rsp_into_full", occ < DEPTH, 1);
    if (ev) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, fdat(exp_pc));
      chk("instr_fault", instr_fault, ferr(exp_pc));
      lastpc  = exp_pc;
      lastdat = fdat(exp_pc);
    end else begin
      chk("hold_pc", instr_pc, lastpc);
      chk("hold_instr", instr, lastdat);
    end
    acc = imem_req_valid && imem_req_ready;
    pop = ev && instr_ready && !redirect_valid;
    if (redirect_valid) begin
      mdisc     = pend.size() - int'(rsp);
      occ       = 0;
      exp_pc    = redirect_pc & 32'hFFFF_FFFC;
      exp_fetch = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop) begin
        exp_pc = exp_pc + 32'd4;
        if (!byp) occ--;
      end
      if (rsp) begin
        if (mdisc > 0) mdisc--;
        else if (!(byp && instr_ready)) occ++;
      end
    end
    if (rsp) void'(pend.pop_front());
    if (acc) begin
      chk("req_addr", imem_req_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      lat = $urandom_range(lat_max, lat_min);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      pend.push_back('{imem_req_addr, due});
      n_acc++;
    end
    prev_redir = redirect_valid;
    cyc++;
  endtask

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;

    // sequential fetch, always-ready memory and decoder
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step();
      if (i == 0) chk("first_req", imem_req_addr, RST_PC);
      if (i >= 3) chk("cont_valid", instr_valid, 1);
    end

    // decoder stall fills the queue, then drains
    do_reset();
    p_dec = 0;
    for (int i = 0; i < 10; i++) step();
    chk("stall_reqs", n_acc, 4);
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_instr_valid", instr_valid, 1);
    chk("stall_head", instr_pc, 32'h0);
    chk("resume_addr", imem_req_addr, 32'h10);
    p_dec = 100;
    for (int i = 0; i < 10; i++) step();
    chk("resumed", n_acc > 4, 1);

    // redirect with responses in flight
    do_reset();
    lat_min = 3;
    lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (pend.size() >= 2) found = 1'b1;
    end
    chk("two_inflight", found, 1);
    f_redir = 1'b1;
    f_tgt   = 32'h100;
    step();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (instr_valid) found = 1'b1;
    end
    chk("redir_found", found, 1);
    chk("redir_first_pc", instr_pc, 32'h100);

    // redirect coinciding with pop and response
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 5; i++) step();
    f_redir = 1'b1;
    f_tgt   = 32'h100;
    step();
    chk("redir_cyc_busy",
        instr_valid && instr_ready && imem_rsp_valid, 1);
    step();
    chk("no_valid_after", instr_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (instr_valid) found = 1'b1;
    end
    chk("redir2_pc", instr_pc, 32'h100);

    // faulting response at 0x8
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (instr_valid && instr_pc == 32'h8) found = 1'b1;
    end
    chk("fault_found", found, 1);
    chk("fault_pc8", instr_fault, 1);

    // address wrap and redirect alignment
    f_redir = 1'b1;
    f_tgt   = 32'hFFFF_FFF8;
    step();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (instr_valid && instr_pc == 32'h0) found = 1'b1;
    end
    chk("wrap_found", found, 1);
    f_redir = 1'b1;
    f_tgt   = 32'h203;
    step();
    step();
    chk("align_addr", imem_req_addr, 32'h200);
    chk("align_valid", imem_req_valid, 1);

    // response-to-decoder latency on an empty queue
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      step();
      if (imem_rsp_valid) found = 1'b1;
    end
    chk("lat_rsp_seen", found, 1);
`ifdef FETCH_BYPASS_EN
    chk("bypass_same_cyc", instr_valid, 1);
`else
    chk("reg_lat0", instr_valid, 0);
`endif
    step();
    chk("reg_lat1", instr_valid, 1);

    // random traffic with a mid-run reset
    p_rdy   = 70;
    p_dec   = 60;
    p_redir = 30;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 1500; i++) step();
    do_reset();
    for (int i = 0; i < 1500; i++) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Generates sequential word-aligned PCs and issues requests to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small prefetch queue and presents one instruction_t plus its PC per cycle to the decoder under a valid/ready handshake.
- Handles control-flow redirects from the execute stage by flushing the queue and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- QUEUE_DEPTH, 4, prefetch queue entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address.
- imem_rsp_valid  in  1  response valid; in order; at least 1 cycle after acceptance; no backpressure.
- imem_rsp_data  in  32  instruction word.
- imem_rsp_err  in  1  access fault for this response.
- redirect_valid  in  1  control-flow redirect.
- redirect_pc  in  32  redirect target.
- instr_valid  out  1  decoder-side valid.
- instr_ready  in  1  decoder-side ready (stall when low).
- instr  out  32  instruction_t to decoder.
- instr_pc  out  32  PC of instr.
- instr_fault  out  1  imem_rsp_err captured with this instr.

Behaviour:
- Interface:
  - One clock; reset is asynchronous and active-high.
  - Ports clk and reset.
  - On reset assertion, the block clears immediately.
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, instr_fault=0.
  - Internal reset values: fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue count=0, inflight=0, discard=0.
  - imem_req_valid may rise the first cycle after reset deasserts.
- Request issue:
  - imem_req_valid = !redirect_valid && (count + inflight < QUEUE_DEPTH).
  - imem_req_addr = fetch_pc.
  - On accept (valid && ready): fetch_pc += 4 (mod 2^32 wrap) and inflight += 1.
  - imem_req_valid and addr hold until ready; they drop only on redirect.
- Response:
  - Each imem_rsp_valid decrements inflight.
  - If discard > 0: the response is dropped and discard decrements.
  - Otherwise the queue is written with {data, rsp_pc, err}, and rsp_pc += 4.
  - The credit rule guarantees a response never arrives at a full queue; the bench asserts this.
- Output:
  - instr_valid = count != 0; instr, instr_pc and instr_fault come from the queue head.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Response-to-instr_valid latency is 1 cycle (registered queue).
  - With the queue empty, instr, instr_pc and instr_fault hold their last values.
- Redirect (single cycle, highest priority):
  - Next state: fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - Queue is flushed (count=0); any pop that cycle is ignored.
  - discard = inflight - (imem_rsp_valid ? 1 : 0); the response arriving that cycle is dropped.
  - inflight is updated normally.
  - No request is issued in the redirect cycle.
  - instr_valid is 0 the cycle after a redirect.
- Back-to-back redirects: each one recomputes discard from the current inflight; the last one wins.
- Faulting responses are queued normally; instr_fault marks them. No special stall.
- Pointer wrap: head/tail are log2(QUEUE_DEPTH) bits and wrap naturally; count is log2(QUEUE_DEPTH)+1 bits.
- Reset mid-operation:
  - Everything clears.
  - The memory side is also reset by the same reset, so no stale responses are expected afterwards.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- When defined, and the queue is empty, discard=0, no redirect and imem_rsp_valid=1:
  - The response drives instr, instr_pc and instr_fault combinationally, with instr_valid=1 in the same cycle.
  - If instr_ready=1, the queue is not written. Otherwise the word is written to the queue as normal.
  - Response-to-decoder latency becomes 0 cycles.
- When not defined: strictly registered, 1-cycle latency as above.

Test Plan:
- Reset release, memory always ready, 1-cycle response, decoder ready:
  - Requests at 0x0, 0x4, 0x8, ...
  - instr_pc sequence 0x0, 0x4, 0x8 with instr_valid continuous after fill.
- Decoder stall, instr_ready=0 for 10 cycles:
  - Exactly 4 requests issue; imem_req_valid then stays 0; count=4.
  - After ready=1, instructions drain in order 0x0..0xC and fetching resumes at 0x10.
- Redirect to 0x100 with 2 responses in flight:
  - Both late responses are dropped.
  - The next instr_pc is 0x100; no instruction from the old stream reaches the decoder.
- Redirect in the same cycle as a pop and a response arrival:
  - Pop ignored, response dropped, instr_valid=0 the next cycle, then 0x100 is fetched.
- imem_rsp_err=1 on the response for 0x8 → instr_pc=0x8 with instr_fault=1; neighbours at 0x4 and 0xC have fault=0.
- Wrap:
  - fetch_pc=0xFFFF_FFFC increments to 0x0000_0000.
  - redirect_pc=0x203 yields fetch 0x200.
  - Under FETCH_BYPASS_EN, an empty queue with a response gives instr_valid in the same cycle.
